// File: rtl/addsub_acc_seq.sv
// addsub_acc_seq: command sequencer and accumulator wrapped around an external
// combinational W-bit adder/subtractor. Commands (LOAD/ADD/SUB/CLEAR) arrive
// over a valid/ready handshake. The block feeds the adder from registers and
// captures its sum during a single EXEC cycle. Each result, with its flags, is
// then offered downstream over a second valid/ready handshake.
// Optional feature: define ADDSUB_SAT_EN for unsigned saturation of ADD/SUB.
module addsub_acc_seq #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_op,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] adder_a,
  output logic [W-1:0] adder_b,
  output logic         adder_ctrl,
  input  logic [W:0]   adder_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_acc,
  output logic         out_carry,
  output logic         out_borrow,
  output logic         out_zero,
  output logic         out_ovf
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [1:0]   r_op;
  logic [W-1:0] r_opnd;
  logic [W-1:0] r_acc;
  logic         r_ctrl;
  logic         r_carry;
  logic         r_borrow;
  logic         r_zero;
  logic         r_ovf;

  logic         w_accept;
  logic         w_release;
  logic [W-1:0] w_acc_next;
  logic         w_carry_next;
  logic         w_borrow_next;
  logic         w_zero_next;
  logic         w_ovf_next;

  // in_ready is gated by rst_n so it reads 0 for the whole reset interval,
  // even though the state register already sits at IDLE.
  assign in_ready  = (r_state == ST_IDLE) && rst_n;
  assign out_valid = (r_state == ST_RESP);
  assign w_accept  = in_valid && in_ready;
  assign w_release = (r_state == ST_RESP) && out_ready;

  // The adder is fed straight from registers so its inputs are stable all EXEC.
  assign adder_a    = r_acc;
  assign adder_b    = r_opnd;
  assign adder_ctrl = r_ctrl;

  assign out_acc    = r_acc;
  assign out_carry  = r_carry;
  assign out_borrow = r_borrow;
  assign out_zero   = r_zero;
  assign out_ovf    = r_ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> EXEC on accept, EXEC lasts one cycle, RESP waits for out_ready.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_next = ST_EXEC;
      ST_EXEC:                w_state_next = ST_RESP;
      ST_RESP: if (w_release) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Result and flag computation from the adder output and the latched opcode.
  always_comb begin
    w_acc_next    = r_acc;
    w_carry_next  = 1'b0;
    w_borrow_next = 1'b0;
    w_ovf_next    = 1'b0;
    case (r_op)
      OP_LOAD: begin
        w_acc_next = r_opnd;
      end
      OP_ADD: begin
        w_acc_next   = adder_sum[W-1:0];
        w_carry_next = adder_sum[W];
        w_ovf_next   = (r_acc[W-1] == r_opnd[W-1]) && (adder_sum[W-1] != r_acc[W-1]);
`ifdef ADDSUB_SAT_EN
        if (adder_sum[W]) w_acc_next = '1;
`endif
      end
      OP_SUB: begin
        // The adder masks its top bit on subtract, so borrow is derived locally.
        w_acc_next    = adder_sum[W-1:0];
        w_borrow_next = (r_acc < r_opnd);
        w_ovf_next    = (r_acc[W-1] != r_opnd[W-1]) && (adder_sum[W-1] != r_acc[W-1]);
`ifdef ADDSUB_SAT_EN
        if (r_acc < r_opnd) w_acc_next = '0;
`endif
      end
      OP_CLEAR: begin
        w_acc_next = '0;
      end
      default: begin
        w_acc_next = '0;
      end
    endcase
    w_zero_next = (w_acc_next == '0);
  end

  // Datapath registers: latch the command on accept, commit the result at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= OP_LOAD;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_ctrl   <= 1'b0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= in_op;
        r_opnd <= in_data;
        r_ctrl <= (in_op == OP_SUB);
      end
      if (r_state == ST_EXEC) begin
        r_acc    <= w_acc_next;
        r_carry  <= w_carry_next;
        r_borrow <= w_borrow_next;
        r_zero   <= w_zero_next;
        r_ovf    <= w_ovf_next;
      end
      if (w_release) begin
        r_ctrl <= 1'b0;
      end
    end
  end

endmodule
